wbdownsz: RTL and testbench
===========================

WBDOWNSZ -- requirements
Module: wbdownsz

Interface
REQ-001 SHALL have parameter ADDRESS_WIDTH, default 28, byte-address width.
REQ-002 SHALL have parameter WIDE_DW, default 512, incoming bus width, an integer multiple of SMALL_DW; N = WIDE_DW/SMALL_DW.
REQ-003 SHALL have parameter SMALL_DW, default 32, outgoing bus width.
REQ-004 SHALL have parameter OPT_LITTLE_ENDIAN, default 0; 0 = lane 0 is the most-significant word.
REQ-005 SHALL have parameter OPT_LOWPOWER, default 0; 1 = zero idle data, address and select outputs.
REQ-006 SHALL have ports i_clk in 1, clock; i_reset in 1, synchronous, active-high reset.
REQ-007 SHALL have wide slave ports i_wcyc, i_wstb, i_wwe in 1; i_waddr in ADDRESS_WIDTH-log2(WIDE_DW/8); i_wdata in WIDE_DW; i_wsel in WIDE_DW/8.
REQ-008 SHALL have wide slave outputs o_wstall, o_wack, o_werr out 1; o_wdata out WIDE_DW.
REQ-009 SHALL have small master outputs o_scyc, o_sstb, o_swe out 1; o_saddr out ADDRESS_WIDTH-log2(SMALL_DW/8); o_sdata out SMALL_DW; o_ssel out SMALL_DW/8.
REQ-010 SHALL have small master inputs i_sstall, i_sack, i_serr in 1; i_sdata in SMALL_DW.

Function
REQ-011 SHALL accept one wide request when i_wstb && !o_wstall, and SHALL hold o_wstall high from acceptance until the cycle after o_wack or o_werr.
REQ-012 SHALL implement states IDLE, ISSUE (beats pending), WAIT (all issued, acks outstanding), and ZERO (request with i_wsel == 0).
REQ-013 SHALL issue only lanes with nonzero select, in ascending lane index; o_saddr = {latched i_waddr, lane index}.
REQ-014 SHALL assert the first o_sstb on the cycle after acceptance, and SHALL advance to the next active lane on each cycle where o_sstb && !i_sstall.
REQ-015 SHALL move from ISSUE to WAIT when the last active lane is accepted downstream.
REQ-016 SHALL count outstanding acks as issued minus acked, sized log2(N)+1; an issue and an ack in the same cycle leave the count unchanged.
REQ-017 SHALL, on reads, write each i_sdata into the lane tracked by a return pointer, which steps through the active lanes in issue order.
REQ-018 SHALL zero lanes with zero select in the returned o_wdata.
REQ-019 SHALL assert o_wack for exactly one cycle, the cycle after the final i_sack, then return to IDLE.
REQ-020 SHALL, for i_wsel == 0 (ZERO state), issue no downstream cycle and assert o_wack on the cycle after acceptance with o_wdata = 0.
REQ-021 SHALL hold o_scyc high from acceptance through the final ack or error.
REQ-022 SHALL, on i_serr while o_scyc, drop o_scyc and o_sstb next cycle, assert o_werr for one cycle, suppress o_wack, and go to IDLE.
REQ-023 SHALL, on i_wcyc low mid-operation, drop o_scyc and o_sstb next cycle, produce no o_wack or o_werr, and go to IDLE; late i_sack is ignored.
REQ-024 SHALL never assert o_wack and o_werr in the same cycle.
REQ-025 SHALL, with OPT_LOWPOWER=1, drive o_sdata, o_ssel and o_saddr to 0 whenever o_sstb is low.

Reset
REQ-026 SHALL, on i_reset, go to IDLE with the outstanding count 0 and o_scyc, o_sstb, o_wack, o_werr at 0.
REQ-027 SHALL, on i_reset, set o_wstall to 0, o_wdata to 0, and o_saddr, o_sdata, o_ssel to 0.
REQ-028 SHALL give reset priority over every other event, including mid-transfer.

Structure
REQ-029 SHALL place the state encoding and the lane-index width function in the shared bus-bridge package.
REQ-030 SHALL use one sub-module, wbdownsz_lanesel: a combinational next-active-lane finder given the select mask and the current lane, shared by the issue and return pointers.

Verification
REQ-031 Bench SHALL use WIDE_DW=128 and SMALL_DW=32 (N=4), big-endian.
REQ-032 Write, i_waddr=0x10, i_wsel=16'hFFFF -> 4 beats at o_saddr 0x40..0x43; o_wack one cycle after the 4th i_sack.
REQ-033 Read, i_wsel=16'h0F0F -> beats at lanes 1 and 3 only; o_wdata = {32'h0, D1, 32'h0, D3}.
REQ-034 i_wsel=0 -> no o_scyc; o_wack on the cycle after acceptance.
REQ-035 i_sstall held high for 3 cycles on beat 2 -> o_saddr and o_sdata stable throughout; total beat count unchanged.
REQ-036 i_serr on beat 2 of 4 -> o_werr for one cycle, no o_wack, o_scyc low the next cycle, next request accepted normally.
REQ-037 i_wcyc dropped after beat 1, then i_reset asserted mid-WAIT -> all outputs return to their reset values; no stray ack afterwards.

Source files
------------

// File: rtl/wbdownsz_pkg.sv
// Shared bus-bridge definitions: bridge state encoding and lane-index sizing.
package wbdownsz_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_ZERO
  } bridge_state_e;

  // A single-lane bridge still carries a one-bit lane index.
  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/wbdownsz_lanesel.sv
// Finds the lowest active lane after the current one (or at it, when incl is set).
module wbdownsz_lanesel
  import wbdownsz_pkg::*;
#(
  parameter int N  = 16,
  parameter int LW = lane_w(N)
) (
  input  logic [N-1:0]  mask,
  input  logic [LW-1:0] cur,
  input  logic          incl,
  output logic [LW-1:0] nxt,
  output logic          found
);

  // Scanning downward lets the lowest qualifying lane win.
  always_comb begin
    nxt   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(cur)) || (incl && (i == int'(cur))))) begin
        nxt   = LW'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wbdownsz.sv
// Wishbone downsizer: splits one wide request into narrow beats for the selected lanes only.
module wbdownsz
  import wbdownsz_pkg::*;
#(
  parameter int ADDRESS_WIDTH     = 28,
  parameter int WIDE_DW           = 512,
  parameter int SMALL_DW          = 32,
  parameter bit OPT_LITTLE_ENDIAN = 1'b0,
  parameter bit OPT_LOWPOWER      = 1'b0
) (
  input  logic                                            i_clk,
  input  logic                                            i_reset,
  input  logic                                            i_wcyc,
  input  logic                                            i_wstb,
  input  logic                                            i_wwe,
  input  logic [ADDRESS_WIDTH-$clog2(WIDE_DW/8)-1:0]      i_waddr,
  input  logic [WIDE_DW-1:0]                              i_wdata,
  input  logic [WIDE_DW/8-1:0]                            i_wsel,
  output logic                                            o_wstall,
  output logic                                            o_wack,
  output logic                                            o_werr,
  output logic [WIDE_DW-1:0]                              o_wdata,
  output logic                                            o_scyc,
  output logic                                            o_sstb,
  output logic                                            o_swe,
  output logic [ADDRESS_WIDTH-$clog2(SMALL_DW/8)-1:0]     o_saddr,
  output logic [SMALL_DW-1:0]                             o_sdata,
  output logic [SMALL_DW/8-1:0]                           o_ssel,
  input  logic                                            i_sstall,
  input  logic                                            i_sack,
  input  logic                                            i_serr,
  input  logic [SMALL_DW-1:0]                             i_sdata
);

  localparam int N   = WIDE_DW / SMALL_DW;
  localparam int LW  = lane_w(N);
  localparam int CW  = LW + 1;
  localparam int SSW = SMALL_DW / 8;
  localparam int WAW = ADDRESS_WIDTH - $clog2(WIDE_DW / 8);
  localparam int SAW = ADDRESS_WIDTH - $clog2(SMALL_DW / 8);

  bridge_state_e state, state_nxt;

  logic [N-1:0]         mask_in, mask_r;
  logic [LW-1:0]        first_lane, issue_ptr, issue_next, ret_ptr, ret_next;
  logic                 first_found, issue_more, ret_more;
  logic [WAW-1:0]       addr_r;
  logic [WIDE_DW-1:0]   data_r;
  logic [WIDE_DW/8-1:0] sel_r;
  logic                 we_r;
  logic [CW-1:0]        pending;
  logic [SAW-1:0]       saddr_r;
  logic [SMALL_DW-1:0]  sdata_r;
  logic [SSW-1:0]       ssel_r;
  logic                 accept, busy, issued, last_issue, ack_ok, done;
  int                   ret_base;

  // Big-endian places lane 0 in the most-significant word.
  function automatic int lane_pos(input int lane);
    return OPT_LITTLE_ENDIAN ? lane : (N - 1 - lane);
  endfunction

  function automatic logic [SMALL_DW-1:0] lane_word(input logic [WIDE_DW-1:0] w,
                                                    input logic [LW-1:0] lane);
    return w[lane_pos(int'(lane))*SMALL_DW +: SMALL_DW];
  endfunction

  function automatic logic [SSW-1:0] lane_sel(input logic [WIDE_DW/8-1:0] s,
                                              input logic [LW-1:0] lane);
    return s[lane_pos(int'(lane))*SSW +: SSW];
  endfunction

  always_comb begin
    mask_in = '0;
    for (int i = 0; i < N; i++) begin
      mask_in[i] = |i_wsel[lane_pos(i)*SSW +: SSW];
    end
  end

  wbdownsz_lanesel #(.N(N), .LW(LW)) u_first (
    .mask(mask_in), .cur({LW{1'b0}}), .incl(1'b1), .nxt(first_lane), .found(first_found)
  );

  wbdownsz_lanesel #(.N(N), .LW(LW)) u_issue (
    .mask(mask_r), .cur(issue_ptr), .incl(1'b0), .nxt(issue_next), .found(issue_more)
  );

  wbdownsz_lanesel #(.N(N), .LW(LW)) u_ret (
    .mask(mask_r), .cur(ret_ptr), .incl(1'b0), .nxt(ret_next), .found(ret_more)
  );

  assign accept     = i_wcyc && i_wstb && !o_wstall;
  assign busy       = (state == ST_ISSUE) || (state == ST_WAIT);
  assign issued     = o_sstb && !i_sstall;
  assign last_issue = issued && !issue_more;
  // Acks with nothing outstanding are stray and must not move the count.
  assign ack_ok     = i_sack && ((pending != '0) || issued);
  assign done       = busy && i_wcyc && !i_serr && ack_ok &&
                      (((state == ST_WAIT) && (pending == CW'(1))) ||
                       (last_issue && (pending == '0)));
  assign ret_base   = lane_pos(int'(ret_ptr)) * SMALL_DW;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (accept) state_nxt = first_found ? ST_ISSUE : ST_ZERO;
      ST_ISSUE: begin
        if (!i_wcyc || i_serr || done) state_nxt = ST_IDLE;
        else if (last_issue)           state_nxt = ST_WAIT;
      end
      ST_WAIT:  if (!i_wcyc || i_serr || done) state_nxt = ST_IDLE;
      ST_ZERO:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_ff @(posedge i_clk) begin
    if (accept) begin
      addr_r <= i_waddr;
      data_r <= i_wdata;
      sel_r  <= i_wsel;
      we_r   <= i_wwe;
      mask_r <= mask_in;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_scyc    <= 1'b0;
      o_sstb    <= 1'b0;
      o_wack    <= 1'b0;
      o_werr    <= 1'b0;
      pending   <= '0;
      issue_ptr <= '0;
      ret_ptr   <= '0;
      o_wdata   <= '0;
      saddr_r   <= '0;
      sdata_r   <= '0;
      ssel_r    <= '0;
    end else begin
      o_wack <= 1'b0;
      o_werr <= 1'b0;
      if (accept) begin
        issue_ptr <= first_lane;
        ret_ptr   <= first_lane;
        pending   <= '0;
        o_wdata   <= '0;
        if (first_found) begin
          o_scyc  <= 1'b1;
          o_sstb  <= 1'b1;
          saddr_r <= {i_waddr, first_lane};
          sdata_r <= lane_word(i_wdata, first_lane);
          ssel_r  <= lane_sel(i_wsel, first_lane);
        end else begin
          o_wack  <= 1'b1;
        end
      end else if (busy) begin
        if (!i_wcyc || i_serr) begin
          // Abort outranks a bus error: a dropped cycle gets no response at all.
          o_scyc  <= 1'b0;
          o_sstb  <= 1'b0;
          pending <= '0;
          o_werr  <= i_wcyc;
        end else begin
          pending <= pending + CW'(issued) - CW'(ack_ok);
          if (issued) begin
            if (issue_more) begin
              issue_ptr <= issue_next;
              saddr_r   <= {addr_r, issue_next};
              sdata_r   <= lane_word(data_r, issue_next);
              ssel_r    <= lane_sel(sel_r, issue_next);
            end else begin
              o_sstb    <= 1'b0;
            end
          end
          if (ack_ok) begin
            if (!we_r) o_wdata[ret_base +: SMALL_DW] <= i_sdata;
            if (ret_more) ret_ptr <= ret_next;
          end
          if (done) begin
            o_scyc <= 1'b0;
            o_sstb <= 1'b0;
            o_wack <= 1'b1;
          end
        end
      end
    end
  end

  assign o_wstall = (state != ST_IDLE) || o_wack || o_werr;
  assign o_swe    = we_r;
  assign o_saddr  = (OPT_LOWPOWER && !o_sstb) ? '0 : saddr_r;
  assign o_sdata  = (OPT_LOWPOWER && !o_sstb) ? '0 : sdata_r;
  assign o_ssel   = (OPT_LOWPOWER && !o_sstb) ? '0 : ssel_r;

endmodule

// File: tb/tb_wbdownsz.sv
// Directed bench for wbdownsz with 128-bit wide side, 32-bit narrow side, big-endian lanes.
module tb_wbdownsz;

  logic         clk = 1'b0;
  logic         i_reset;
  logic         i_wcyc, i_wstb, i_wwe;
  logic [23:0]  i_waddr;
  logic [127:0] i_wdata;
  logic [15:0]  i_wsel;
  logic         o_wstall, o_wack, o_werr;
  logic [127:0] o_wdata;
  logic         o_scyc, o_sstb, o_swe;
  logic [25:0]  o_saddr;
  logic [31:0]  o_sdata;
  logic [3:0]   o_ssel;
  logic         i_sstall, i_sack, i_serr;
  logic [31:0]  i_sdata;

  always #5 clk = ~clk;

  wbdownsz #(
    .ADDRESS_WIDTH(28), .WIDE_DW(128), .SMALL_DW(32),
    .OPT_LITTLE_ENDIAN(1'b0), .OPT_LOWPOWER(1'b0)
  ) dut (
    .i_clk(clk), .i_reset(i_reset),
    .i_wcyc(i_wcyc), .i_wstb(i_wstb), .i_wwe(i_wwe),
    .i_waddr(i_waddr), .i_wdata(i_wdata), .i_wsel(i_wsel),
    .o_wstall(o_wstall), .o_wack(o_wack), .o_werr(o_werr), .o_wdata(o_wdata),
    .o_scyc(o_scyc), .o_sstb(o_sstb), .o_swe(o_swe),
    .o_saddr(o_saddr), .o_sdata(o_sdata), .o_ssel(o_ssel),
    .i_sstall(i_sstall), .i_sack(i_sack), .i_serr(i_serr), .i_sdata(i_sdata)
  );

  typedef struct {
    logic         we;
    logic [23:0]  addr;
    logic [15:0]  sel;
    logic [127:0] data;
    int           beats;
    logic [25:0]  a_first;
    logic [25:0]  a_last;
    logic [3:0]   sel_first;
    logic [3:0]   sel_last;
    logic [31:0]  d_first;
    logic [127:0] rdata;
  } vec_t;

  vec_t vecs[7];

  int nvec = 0, nfail = 0;
  int cyc = 0, beats = 0, acc_cyc = -1, sack_cyc = -1, wack_cyc = -1;
  int wack_cnt = 0, werr_cnt = 0, stall_viol = 0;
  int stall_on_beat = -1, stall_left = 0, err_on_beat = -1;
  logic hold_ack = 1'b0, ack_pipe = 1'b0, err_pipe = 1'b0;
  logic [31:0] ack_data = '0;
  logic scyc_seen = 1'b0, scyc_at_err = 1'b1, swe_first = 1'b0, stalled_prev = 1'b0;
  logic [25:0] prev_addr = '0;
  logic [31:0] prev_data = '0;
  logic [127:0] wdata_at_ack = '0;
  logic [25:0] beat_addr[$];
  logic [31:0] beat_data[$];
  logic [3:0]  beat_sel[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: sample at the falling edge, then act as the narrow slave for the next rising edge.
  task automatic tick();
    @(negedge clk);
    cyc++;
    if (o_wack) begin wack_cnt++; wack_cyc = cyc; wdata_at_ack = o_wdata; end
    if (o_werr) begin werr_cnt++; scyc_at_err = o_scyc; end
    if (o_scyc) scyc_seen = 1'b1;
    if (stalled_prev && o_sstb && ((o_saddr !== prev_addr) || (o_sdata !== prev_data)))
      stall_viol++;
    i_sack  = ack_pipe && !err_pipe;
    i_serr  = err_pipe;
    i_sdata = ack_data;
    if (ack_pipe && !err_pipe) sack_cyc = cyc;
    ack_pipe = 1'b0;
    err_pipe = 1'b0;
    i_sstall = 1'b0;
    if (o_sstb && (beats == stall_on_beat) && (stall_left > 0)) begin
      i_sstall = 1'b1;
      stall_left--;
    end
    if (o_sstb && !i_sstall) begin
      beat_addr.push_back(o_saddr);
      beat_data.push_back(o_sdata);
      beat_sel.push_back(o_ssel);
      if (beats == 0) swe_first = o_swe;
      ack_pipe = !hold_ack;
      err_pipe = !hold_ack && (beats == err_on_beat);
      ack_data = 32'hC0DE_0000 + {6'd0, o_saddr};
      beats++;
    end
    stalled_prev = o_sstb && i_sstall;
    prev_addr = o_saddr;
    prev_data = o_sdata;
  endtask

  task automatic reset_track();
    beats = 0; wack_cnt = 0; werr_cnt = 0; stall_viol = 0;
    sack_cyc = -1; wack_cyc = -1; acc_cyc = -1;
    scyc_seen = 1'b0; scyc_at_err = 1'b1; swe_first = 1'b0; wdata_at_ack = '0;
    beat_addr.delete(); beat_data.delete(); beat_sel.delete();
  endtask

  task automatic accept_req(input logic we, input logic [23:0] addr,
                            input logic [15:0] sel, input logic [127:0] data);
    logic acc;
    tick();
    i_wcyc = 1'b1; i_wstb = 1'b1; i_wwe = we;
    i_waddr = addr; i_wsel = sel; i_wdata = data;
    acc = 1'b0;
    for (int t = 0; t < 16 && !acc; t++) begin
      if (!o_wstall) begin acc = 1'b1; acc_cyc = cyc; end
      tick();
    end
    i_wstb = 1'b0;
    chk("accept_in_time", {127'd0, acc}, 128'd1);
  endtask

  task automatic run_req(input logic we, input logic [23:0] addr,
                         input logic [15:0] sel, input logic [127:0] data);
    reset_track();
    accept_req(we, addr, sel, data);
    for (int t = 0; t < 40 && wack_cnt == 0 && werr_cnt == 0; t++) tick();
    chk("response_in_time", {127'd0, (wack_cnt + werr_cnt) > 0}, 128'd1);
    repeat (3) tick();
    i_wcyc = 1'b0;
    tick();
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_wstall"}, {127'd0, o_wstall}, 128'd0);
    chk({tag, "_wack"},   {127'd0, o_wack},   128'd0);
    chk({tag, "_werr"},   {127'd0, o_werr},   128'd0);
    chk({tag, "_scyc"},   {127'd0, o_scyc},   128'd0);
    chk({tag, "_sstb"},   {127'd0, o_sstb},   128'd0);
    chk({tag, "_wdata"},  o_wdata,            128'd0);
    chk({tag, "_saddr"},  {102'd0, o_saddr},  128'd0);
    chk({tag, "_sdata"},  {96'd0, o_sdata},   128'd0);
    chk({tag, "_ssel"},   {124'd0, o_ssel},   128'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 24'h10, 16'hFFFF, 128'h11111111_22222222_33333333_44444444,
                4, 26'h40, 26'h43, 4'hF, 4'hF, 32'h11111111, 128'd0};
    vecs[1] = '{1'b0, 24'h20, 16'h0F0F, 128'd0,
                2, 26'h81, 26'h83, 4'hF, 4'hF, 32'h0,
                128'h00000000_C0DE0081_00000000_C0DE0083};
    vecs[2] = '{1'b0, 24'h09, 16'h0000, 128'd0,
                0, 26'h0, 26'h0, 4'h0, 4'h0, 32'h0, 128'd0};
    vecs[3] = '{1'b0, 24'h03, 16'hF000, 128'd0,
                1, 26'h0C, 26'h0C, 4'hF, 4'hF, 32'h0,
                128'hC0DE000C_00000000_00000000_00000000};
    vecs[4] = '{1'b1, 24'h07, 16'h00F0, 128'hAAAA0000_BBBB1111_CCCC2222_DDDD3333,
                1, 26'h1E, 26'h1E, 4'hF, 4'hF, 32'hCCCC2222, 128'd0};
    vecs[5] = '{1'b1, 24'h05, 16'h8421, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                4, 26'h14, 26'h17, 4'h8, 4'h1, 32'h01234567, 128'd0};
    vecs[6] = '{1'b0, 24'h01, 16'hFFFF, 128'd0,
                4, 26'h04, 26'h07, 4'hF, 4'hF, 32'h0,
                128'hC0DE0004_C0DE0005_C0DE0006_C0DE0007};

    i_reset = 1'b1; i_wcyc = 1'b0; i_wstb = 1'b0; i_wwe = 1'b0;
    i_waddr = '0; i_wdata = '0; i_wsel = '0;
    i_sstall = 1'b0; i_sack = 1'b0; i_serr = 1'b0; i_sdata = '0;
    tick();
    tick();
    check_idle("reset");
    i_reset = 1'b0;

    for (int v = 0; v < 7; v++) begin
      run_req(vecs[v].we, vecs[v].addr, vecs[v].sel, vecs[v].data);
      chk($sformatf("v%0d_beats", v), 128'(beats), 128'(vecs[v].beats));
      chk($sformatf("v%0d_wack_count", v), 128'(wack_cnt), 128'd1);
      chk($sformatf("v%0d_werr_count", v), 128'(werr_cnt), 128'd0);
      chk($sformatf("v%0d_scyc_seen", v), {127'd0, scyc_seen}, {127'd0, vecs[v].beats > 0});
      if (vecs[v].beats > 0) begin
        chk($sformatf("v%0d_addr_first", v), {102'd0, beat_addr[0]}, {102'd0, vecs[v].a_first});
        chk($sformatf("v%0d_addr_last", v), {102'd0, beat_addr[beat_addr.size()-1]},
            {102'd0, vecs[v].a_last});
        chk($sformatf("v%0d_sel_first", v), {124'd0, beat_sel[0]}, {124'd0, vecs[v].sel_first});
        chk($sformatf("v%0d_sel_last", v), {124'd0, beat_sel[beat_sel.size()-1]},
            {124'd0, vecs[v].sel_last});
        chk($sformatf("v%0d_swe", v), {127'd0, swe_first}, {127'd0, vecs[v].we});
        chk($sformatf("v%0d_ack_latency", v), 128'(wack_cyc), 128'(sack_cyc + 1));
        if (vecs[v].we)
          chk($sformatf("v%0d_data_first", v), {96'd0, beat_data[0]}, {96'd0, vecs[v].d_first});
      end else begin
        chk($sformatf("v%0d_zero_latency", v), 128'(wack_cyc), 128'(acc_cyc + 1));
      end
      if (!vecs[v].we)
        chk($sformatf("v%0d_rdata", v), wdata_at_ack, vecs[v].rdata);
    end

    // Narrow slave stalls the second beat for three cycles.
    stall_on_beat = 1; stall_left = 3;
    run_req(1'b1, 24'h10, 16'hFFFF, 128'h11111111_22222222_33333333_44444444);
    chk("stall_beats", 128'(beats), 128'd4);
    chk("stall_consumed", 128'(stall_left), 128'd0);
    chk("stall_stable", 128'(stall_viol), 128'd0);
    chk("stall_beat2_addr", {102'd0, beat_addr[1]}, 128'h41);
    chk("stall_beat2_data", {96'd0, beat_data[1]}, 128'h22222222);
    chk("stall_wack_count", 128'(wack_cnt), 128'd1);
    chk("stall_ack_latency", 128'(wack_cyc), 128'(sack_cyc + 1));
    stall_on_beat = -1;

    // Bus error on beat 2 of 4, then an ordinary read must still work.
    err_on_beat = 1;
    run_req(1'b1, 24'h10, 16'hFFFF, 128'h11111111_22222222_33333333_44444444);
    chk("err_werr_count", 128'(werr_cnt), 128'd1);
    chk("err_wack_count", 128'(wack_cnt), 128'd0);
    chk("err_scyc_dropped", {127'd0, scyc_at_err}, 128'd0);
    err_on_beat = -1;
    run_req(1'b0, 24'h20, 16'h0F0F, 128'd0);
    chk("after_err_wack", 128'(wack_cnt), 128'd1);
    chk("after_err_rdata", wdata_at_ack, 128'h00000000_C0DE0081_00000000_C0DE0083);

    // Master drops the cycle after beat 1; the late ack must be ignored.
    reset_track();
    accept_req(1'b0, 24'h02, 16'hFFFF, 128'd0);
    for (int t = 0; t < 10 && beats < 1; t++) tick();
    i_wcyc = 1'b0;
    tick();
    chk("abort_scyc", {127'd0, o_scyc}, 128'd0);
    chk("abort_sstb", {127'd0, o_sstb}, 128'd0);
    repeat (4) tick();
    chk("abort_wack_count", 128'(wack_cnt), 128'd0);
    chk("abort_werr_count", 128'(werr_cnt), 128'd0);

    // Reset lands while waiting on outstanding acks.
    reset_track();
    hold_ack = 1'b1;
    accept_req(1'b0, 24'h02, 16'hFFFF, 128'd0);
    for (int t = 0; t < 10 && beats < 4; t++) tick();
    tick();
    chk("wait_scyc", {127'd0, o_scyc}, 128'd1);
    chk("wait_sstb", {127'd0, o_sstb}, 128'd0);
    i_reset = 1'b1;
    tick();
    check_idle("midreset");
    i_reset = 1'b0;
    hold_ack = 1'b0;
    ack_pipe = 1'b1;
    ack_data = 32'hDEAD_BEEF;
    i_wcyc = 1'b0;
    repeat (4) tick();
    chk("postreset_wack_count", 128'(wack_cnt), 128'd0);
    chk("postreset_werr_count", 128'(werr_cnt), 128'd0);
    check_idle("postreset");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
